// File: rtl/reg_write_demux.sv
// Write-side demux for the register file: 2-entry request FIFO feeding a registered one-hot
// write-enable vector. Optional macro REG_WRITE_ZERO_REG_EN makes register NREG-1 hard-wired zero.
module reg_write_demux #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic [NREG-1:0]  wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic [15:0]      wr_count
);

  logic [1:0]       count_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [AW-1:0]    addr_q [2];
  logic [WIDTH-1:0] data_q [2];
  logic [NREG-1:0]  wr_en_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [15:0]      wr_count_q;

  logic             push, pop, issue;
  logic [AW-1:0]    head_addr;
  logic [WIDTH-1:0] head_data;
  logic [NREG-1:0]  wr_en_d;

  assign in_ready  = (count_q < 2'd2);
  assign busy      = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  // The array never stalls, so the head leaves the FIFO every cycle it is present.
  assign pop       = busy;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

`ifdef REG_WRITE_ZERO_REG_EN
  assign issue = pop && (head_addr != AW'(NREG - 1));
`else
  assign issue = pop;
`endif

  always_comb begin
    wr_en_d = '0;
    if (issue) begin
      wr_en_d = NREG'(1) << head_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_count_q <= 16'd0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= in_addr;
        data_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
      wr_en_q <= wr_en_d;
      if (issue) begin
        wr_data_q  <= head_data;
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_demux.sv
// Randomised scoreboard bench for reg_write_demux: a queue-based FIFO model predicts every
// cycle's outputs, and a negedge monitor pops and compares them.
module tb_reg_write_demux;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [AW-1:0]    in_addr = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic [NREG-1:0]  wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic [15:0]      wr_count;

  reg_write_demux #(.NREG(NREG), .AW(AW), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } req_t;

  typedef struct {
    logic [NREG-1:0]  en;
    logic [WIDTH-1:0] data;
    logic [15:0]      cnt;
    logic             busy;
    logic             rdy;
  } exp_t;

  req_t pend[$];
  exp_t expq[$];
  logic [WIDTH-1:0] m_data = '0;
  logic [15:0]      m_cnt  = '0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_zero_reg(input logic [AW-1:0] a);
`ifdef REG_WRITE_ZERO_REG_EN
    return int'(a) == NREG - 1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, take the edge, then advance the reference model.
  task automatic cycle(input bit v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                       input bit rst);
    bit   accept;
    req_t r;
    exp_t e;
    reset    = rst;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    accept   = v && (pend.size() < 2);
    @(posedge clk);
    e.en = '0;
    if (rst) begin
      pend.delete();
      m_data = '0;
      m_cnt  = '0;
    end else begin
      if (pend.size() > 0) begin
        r = pend.pop_front();
        if (!is_zero_reg(r.addr)) begin
          e.en[r.addr] = 1'b1;
          m_data = r.data;
          m_cnt  = m_cnt + 16'd1;
        end
      end
      if (accept) begin
        r.addr = a;
        r.data = d;
        pend.push_back(r);
      end
    end
    e.data = m_data;
    e.cnt  = m_cnt;
    e.busy = pend.size() != 0;
    e.rdy  = pend.size() < 2;
    expq.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("wr_en", 64'(wr_en), 64'(e.en));
        chk("wr_data", wr_data, e.data);
        chk("wr_count", 64'(wr_count), 64'(e.cnt));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("in_ready", 64'(in_ready), 64'(e.rdy));
      end
    end
  end

  initial begin : driver
    logic [AW-1:0] a;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    // Request offered right after reset release plus consecutive follow-ups.
    cycle(1'b1, AW'(3), 64'h1111, 1'b0);
    cycle(1'b1, AW'(4), 64'h2222, 1'b0);
    cycle(1'b1, AW'(6), 64'h3333, 1'b0);
    idle(3);
    // Single write
    cycle(1'b1, AW'(5), 64'hDEAD_BEEF_0000_0001, 1'b0);
    idle(3);
    // Streaming walk across every register
    for (int i = 0; i < int'(NREG); i++) cycle(1'b1, AW'(i), 64'(i * 3), 1'b0);
    idle(3);
    // Same-address ordering
    cycle(1'b1, AW'(7), 64'd1, 1'b0);
    cycle(1'b1, AW'(7), 64'd2, 1'b0);
    idle(3);
    // Top register (zero register when the feature is enabled)
    cycle(1'b1, AW'(NREG - 1), 64'hFF, 1'b0);
    idle(3);
    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
            {$urandom, $urandom}, 1'b0);
    end
    idle(2);
    // Reset mid-stream with one entry pending: it must never be issued
    cycle(1'b1, AW'(9), 64'hBAD0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    idle(3);
    // Counter wrap: 65535 counted writes then one more
    for (int i = 0; i < 65535; i++) begin
      a = AW'($urandom_range(0, NREG - 2));
      cycle(1'b1, a, 64'(i), 1'b0);
    end
    idle(2);
    cycle(1'b1, AW'(2), 64'hCAFE, 1'b0);
    idle(3);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    chk("final_wr_count", 64'(wr_count), 64'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
